// File: rtl/vending_machine.sv
// Coin-operated vending controller: credit accumulates in 5-unit steps, one-hot
// item selection vends with change or requests more coins. All outputs registered.
module vending_machine #(
  parameter int CREDIT_W = 5,
  parameter int PRICE0   = 1,
  parameter int PRICE1   = 2,
  parameter int PRICE2   = 4,
  parameter int PRICE3   = 3,
  parameter int PRICE4   = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          coin,
  input  logic [4:0]          item,
  output logic [CREDIT_W-1:0] change_coins,
  output logic                enter_more_coins,
  output logic [CREDIT_W-1:0] state_current,
  output logic [4:0]          item_out
);

  localparam logic [CREDIT_W-1:0] P0 = CREDIT_W'(PRICE0);
  localparam logic [CREDIT_W-1:0] P1 = CREDIT_W'(PRICE1);
  localparam logic [CREDIT_W-1:0] P2 = CREDIT_W'(PRICE2);
  localparam logic [CREDIT_W-1:0] P3 = CREDIT_W'(PRICE3);
  localparam logic [CREDIT_W-1:0] P4 = CREDIT_W'(PRICE4);

  logic [CREDIT_W-1:0] credit_r;
  logic [CREDIT_W-1:0] change_r;
  logic                more_r;
  logic [4:0]          item_r;

  logic [CREDIT_W-1:0] coin_val_s;
  logic [CREDIT_W:0]   sum_full_s;
  logic [CREDIT_W-1:0] sum_s;
  logic [CREDIT_W-1:0] price_s;
  logic                item_ok_s;
  logic [CREDIT_W-1:0] credit_nxt_s;
  logic [CREDIT_W-1:0] change_nxt_s;
  logic                more_nxt_s;
  logic [4:0]          item_nxt_s;

  // Credit the coin first, then resolve any selection against the combined sum.
  always_comb begin
    coin_val_s   = {CREDIT_W{1'b0}};
    price_s      = {CREDIT_W{1'b0}};
    item_ok_s    = 1'b0;
    change_nxt_s = {CREDIT_W{1'b0}};
    more_nxt_s   = 1'b0;
    item_nxt_s   = 5'b00000;

    case (coin)
      4'b0001: coin_val_s = CREDIT_W'(1);
      4'b0010: coin_val_s = CREDIT_W'(2);
      4'b0100: coin_val_s = CREDIT_W'(4);
      4'b1000: coin_val_s = CREDIT_W'(10);
      default: coin_val_s = {CREDIT_W{1'b0}};
    endcase

    sum_full_s = {1'b0, credit_r} + {1'b0, coin_val_s};
    // A coin that would overflow the credit register is simply not taken.
    if (sum_full_s[CREDIT_W]) begin
      sum_s = credit_r;
    end else begin
      sum_s = sum_full_s[CREDIT_W-1:0];
    end
    credit_nxt_s = sum_s;

    case (item)
      5'b00001: begin price_s = P0; item_ok_s = 1'b1; end
      5'b00010: begin price_s = P1; item_ok_s = 1'b1; end
      5'b00100: begin price_s = P2; item_ok_s = 1'b1; end
      5'b01000: begin price_s = P3; item_ok_s = 1'b1; end
      5'b10000: begin price_s = P4; item_ok_s = 1'b1; end
      default:  begin price_s = {CREDIT_W{1'b0}}; item_ok_s = 1'b0; end
    endcase

    if (item_ok_s) begin
      if (sum_s >= price_s) begin
        change_nxt_s = sum_s - price_s;
        item_nxt_s   = item;
        credit_nxt_s = {CREDIT_W{1'b0}};
      end else begin
        more_nxt_s = 1'b1;
      end
    end else begin
      credit_nxt_s = sum_s;
    end
  end

  // Credit register and one-cycle output pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credit_r <= {CREDIT_W{1'b0}};
      change_r <= {CREDIT_W{1'b0}};
      more_r   <= 1'b0;
      item_r   <= 5'b00000;
    end else begin
      credit_r <= credit_nxt_s;
      change_r <= change_nxt_s;
      more_r   <= more_nxt_s;
      item_r   <= item_nxt_s;
    end
  end

  assign state_current    = credit_r;
  assign change_coins     = change_r;
  assign enter_more_coins = more_r;
  assign item_out         = item_r;

endmodule

// File: tb/tb_vending_machine.sv
// Directed bench for vending_machine: hand-computed credit, change and pulse
// expectations across coin counting, vends, refusals, overflow and reset.
module tb_vending_machine;

  logic       clk;
  logic       rst;
  logic [3:0] coin;
  logic [4:0] item;
  logic [4:0] change_coins;
  logic       enter_more_coins;
  logic [4:0] state_current;
  logic [4:0] item_out;

  int n_checks;
  int n_fails;

  vending_machine dut (
    .clk              (clk),
    .rst              (rst),
    .coin             (coin),
    .item             (item),
    .change_coins     (change_coins),
    .enter_more_coins (enter_more_coins),
    .state_current    (state_current),
    .item_out         (item_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Apply one cycle of coin/item, then sample just after the edge.
  task automatic step(input logic [3:0] c, input logic [4:0] it);
    @(negedge clk);
    coin = c;
    item = it;
    @(posedge clk);
    #1;
    coin = 4'b0000;
    item = 5'b00000;
  endtask

  task automatic expect_out(input string tag, input logic [4:0] st, input logic [4:0] chg,
                            input logic more, input logic [4:0] io);
    check({tag, "_state"},  {27'd0, state_current}, {27'd0, st});
    check({tag, "_change"}, {27'd0, change_coins},  {27'd0, chg});
    check({tag, "_more"},   {31'd0, enter_more_coins}, {31'd0, more});
    check({tag, "_item"},   {27'd0, item_out},      {27'd0, io});
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    coin = 4'b0000;
    item = 5'b00000;
    rst  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    expect_out("reset", 5'd0, 5'd0, 1'b0, 5'd0);
    @(negedge clk);
    rst = 1'b1;
    step(4'b0000, 5'b00000);
    expect_out("idle", 5'd0, 5'd0, 1'b0, 5'd0);

    // Four 5-coins, then item3 (price 3)
    for (int i = 1; i <= 4; i++) begin
      step(4'b0001, 5'b00000);
      check($sformatf("count5_%0d", i), {27'd0, state_current}, i);
    end
    step(4'b0000, 5'b01000);
    expect_out("vend4", 5'd0, 5'd1, 1'b0, 5'b01000);
    step(4'b0000, 5'b00000);
    expect_out("vend4_after", 5'd0, 5'd0, 1'b0, 5'd0);

    repeat (5) step(4'b0001, 5'b00000);
    check("five5", {27'd0, state_current}, 32'd5);
    step(4'b0000, 5'b01000);
    expect_out("vend5", 5'd0, 5'd2, 1'b0, 5'b01000);

    repeat (6) step(4'b0001, 5'b00000);
    step(4'b0000, 5'b01000);
    expect_out("vend6", 5'd0, 5'd3, 1'b0, 5'b01000);

    repeat (5) step(4'b0010, 5'b00000);
    check("five10", {27'd0, state_current}, 32'd10);
    step(4'b0000, 5'b01000);
    expect_out("vend10", 5'd0, 5'd7, 1'b0, 5'b01000);

    // Insufficient credit then exact payment
    repeat (2) step(4'b0001, 5'b00000);
    step(4'b0000, 5'b01000);
    expect_out("short", 5'd2, 5'd0, 1'b1, 5'd0);
    step(4'b0000, 5'b00000);
    expect_out("short_after", 5'd2, 5'd0, 1'b0, 5'd0);
    step(4'b0001, 5'b00000);
    step(4'b0000, 5'b01000);
    expect_out("exact", 5'd0, 5'd0, 1'b0, 5'b01000);

    // Coin and item in the same cycle: coin counted first
    step(4'b0100, 5'b10000);
    expect_out("same_short", 5'd4, 5'd0, 1'b1, 5'd0);
    step(4'b0001, 5'b10000);
    expect_out("same_exact", 5'd0, 5'd0, 1'b0, 5'b10000);
    step(4'b1000, 5'b00001);
    expect_out("coin50_vend", 5'd0, 5'd9, 1'b0, 5'b00001);

    // Overflow and illegal inputs
    repeat (3) step(4'b1000, 5'b00000);
    check("at30", {27'd0, state_current}, 32'd30);
    step(4'b0010, 5'b00000);
    check("overflow", {27'd0, state_current}, 32'd30);
    step(4'b0001, 5'b00000);
    check("fill31", {27'd0, state_current}, 32'd31);
    step(4'b0001, 5'b00000);
    check("overflow31", {27'd0, state_current}, 32'd31);
    step(4'b0011, 5'b00000);
    check("coin_bad", {27'd0, state_current}, 32'd31);
    step(4'b0000, 5'b01100);
    expect_out("item_bad", 5'd31, 5'd0, 1'b0, 5'd0);
    step(4'b0000, 5'b00100);
    expect_out("vend31", 5'd0, 5'd27, 1'b0, 5'b00100);

    // Asynchronous reset mid-count
    repeat (2) step(4'b0001, 5'b00000);
    @(negedge clk);
    coin = 4'b0001;
    #2;
    rst = 1'b0;
    #1;
    expect_out("async_rst", 5'd0, 5'd0, 1'b0, 5'd0);
    @(posedge clk);
    #1;
    check("rst_hold", {27'd0, state_current}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    coin = 4'b0000;
    step(4'b0001, 5'b00000);
    check("post_rst", {27'd0, state_current}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/vending_machine.md
Name: vending_machine

Overview:
Coin-operated vending controller. It accumulates credit from one-hot coin inputs and accepts a one-hot item selection. On a successful vend it returns change as a count of 5-unit coins; on insufficient credit it flags that more coins are needed. It sits between the coin acceptor / keypad front-end and the dispenser / change hopper, in a single clock domain.

Parameters:
- CREDIT_W, 5, width of credit register and change count (units of 5 money).
- PRICE0, 1, price of item bit0 in 5-units (5).
- PRICE1, 2, price of item bit1 (10).
- PRICE2, 4, price of item bit2 (20).
- PRICE3, 3, price of item bit3 (15).
- PRICE4, 5, price of item bit4 (25).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-low.
- coin  input  4  one-hot coin strobe, sampled every posedge: 0001=5, 0010=10, 0100=20, 1000=50; 0000=no coin.
- item  input  5  one-hot item select, sampled every posedge; 00000=none.
- change_coins  output  5  change returned, counted in 5-unit coins; one-cycle pulse, else 0.
- enter_more_coins  output  1  one-cycle pulse: selection refused for insufficient credit.
- state_current  output  5  current credit in 5-units (FSM state number).
- item_out  output  5  one-cycle pulse echoing the vended item; 0 otherwise.

Behaviour:
- Async reset (rst=0): credit=0; change_coins=0, enter_more_coins=0, item_out=0, state_current=0. All outputs are registered.
- FSM state is the credit value 0..31 (units of 5, max 155), exposed directly on state_current.
- Coin counting:
  - Each posedge with a legal one-hot coin adds 1/2/4/10 units.
  - A coin is counted once per cycle it is high, so a coin held N cycles counts N times (front-end pulses one cycle per coin).
  - Non-one-hot coin values are ignored (no credit).
- Overflow: a coin that would push credit above 31 is not credited; credit stays unchanged.
- Item selection at a posedge with a legal one-hot item. Let sum = credit + that cycle's coin (coin credited first).
  - If sum >= price: next cycle change_coins = sum - price, item_out = item, credit = 0, enter_more_coins = 0.
  - If sum < price: credit = sum (coin kept), enter_more_coins = 1, change_coins = 0, item_out = 0.
  - Non-one-hot item values are ignored, with no pulse.
- Latency: vend and change pulses appear on the clock edge that samples item; the values are visible for exactly one cycle, then return to 0.
- Exact payment: change_coins = 0 and item_out still pulses.
- Reset mid-transaction: credit is lost and all outputs clear immediately.
- No reset-to-idle refund path; credit persists until a vend or reset.

Test Plan:
- Reset with rst=0, then release → state_current=0, change_coins=0, enter_more_coins=0.
- Four 5-coins (coin=0001, 4 cycles) → state_current steps 1,2,3,4. Then item=01000 for one cycle → change_coins=1, item_out=01000 for one cycle, state_current=0.
- Five 5-coins → state_current=5. Then item=01000 → change_coins=2, state_current=0.
- Six 5-coins then item=01000 → change_coins=3. Five 10-coins (0010) → state_current=10. Then item=01000 → change_coins=7, state_current=0.
- Insufficient credit: two 5-coins (state_current=2), then item=01000 → enter_more_coins pulses 1, state_current stays 2, change_coins=0. Then one 5-coin and item=01000 → change_coins=0, item_out=01000.
- Overflow and illegal input:
  - At state_current=30, coin=0010 → state_current stays 30.
  - coin=0011 → no change.
  - item=01100 → no pulses.
  - Assert rst=0 mid-count → state_current=0 asynchronously.
